note_sample_reader: RTL and testbench

// Consumer side of the note_address lookup. Takes the packed 45-bit note_addr word
// (three 15-bit phase steps: fundamental, 2nd and 3rd harmonic) and produces one

---
 rtl/note_sample_reader_if.sv | 37 +++
 rtl/note_sample_reader.sv | 134 +++++++++++++
 tb/tb_note_sample_reader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/note_sample_reader_if.sv
// note_sample_reader_if
// Bundles the note lookup, codec request and sine ROM signals of the
// note_sample_reader.
//   note_addr     : packed phase steps {h3, h2, h1}, 15 bits each
//   new_note      : pulse, zero all phases and abort any sequence
//   play          : 1 = advance phases, 0 = silence with frozen phases
//   generate_next : pulse, sample request from the codec
//   rom_addr      : registered quarter-wave sine ROM address
//   rom_data      : ROM output, valid one clock after rom_addr
//   sample_out    : registered signed sample
//   sample_valid  : one-cycle strobe marking a new sample_out
//   busy          : sequence in progress
// master = note source / codec / ROM side, slave = the reader.
interface note_sample_reader_if #(
  parameter int ROM_AW   = 10,
  parameter int SAMPLE_W = 16
);
  logic [44:0]         note_addr;
  logic                new_note;
  logic                play;
  logic                generate_next;
  logic [ROM_AW-1:0]   rom_addr;
  logic [SAMPLE_W-1:0] rom_data;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;
  logic                busy;

  modport master (
    output note_addr, new_note, play, generate_next, rom_data,
    input  rom_addr, sample_out, sample_valid, busy
  );

  modport slave (
    input  note_addr, new_note, play, generate_next, rom_data,
    output rom_addr, sample_out, sample_valid, busy
  );
endinterface

// File: rtl/note_sample_reader.sv
// note_sample_reader
// Turns a packed note_addr word (three 15-bit phase steps: fundamental,
// 2nd and 3rd harmonic) into one signed sample per codec request. Each
// harmonic owns a phase accumulator; all three share a single synchronous
// quarter-wave sine ROM port, visited in turn by the sequencing FSM.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : note_sample_reader_if.slave (note input, codec request,
//           ROM port, sample output, busy)
module note_sample_reader #(
  parameter int PHASE_W  = 22,
  parameter int ROM_AW   = 10,
  parameter int SAMPLE_W = 16
) (
  input logic                 clk,
  input logic                 reset,
  note_sample_reader_if.slave bus
);

  localparam int STEP_W = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADV,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  state_t state, state_next;
  logic   start;

  logic [1:0]                 k;
  logic [PHASE_W-1:0]         phase [3];
  logic [3*STEP_W-1:0]        note_lat;
  logic                       play_lat;
  logic [1:0]                 quad_lat;
  logic signed [SAMPLE_W-1:0] acc;

  logic [STEP_W-1:0]          step_k;
  logic [PHASE_W-1:0]         ph_cur;
  logic [PHASE_W-1:0]         ph_new;
  logic [1:0]                 q_new;
  logic [ROM_AW-1:0]          idx_new;
  logic signed [SAMPLE_W-1:0] d;
  logic signed [SAMPLE_W-1:0] d_shift;

  // new_note aborts a sequence from any state, like reset but keeping outputs
  always_ff @(posedge clk) begin
    if (reset || bus.new_note) state <= S_IDLE;
    else                       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.generate_next) begin
          state_next = S_ADV;
          start      = 1'b1;
        end
      end
      S_ADV:   state_next = S_WAIT;
      S_WAIT:  state_next = S_ACC;
      S_ACC:   state_next = (k == 2'd2) ? S_OUT : S_ADV;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.busy = (state != S_IDLE);

  always_comb begin
    step_k  = note_lat[STEP_W*k +: STEP_W];
    ph_cur  = phase[k];
    ph_new  = play_lat ? ph_cur + {{(PHASE_W-STEP_W){1'b0}}, step_k} : ph_cur;
    q_new   = ph_new[PHASE_W-1 -: 2];
    idx_new = ph_new[PHASE_W-3 -: ROM_AW];
    // Upper half of the wave is the negated lower half
    d       = quad_lat[1] ? -$signed(bus.rom_data) : $signed(bus.rom_data);
    // Fundamental weighted 1/2, each harmonic 1/4: the sum cannot overflow
    d_shift = (k == 2'd0) ? (d >>> 1) : (d >>> 2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) phase[i] <= '0;
      bus.rom_addr     <= '0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      acc              <= '0;
      k                <= '0;
      note_lat         <= '0;
      play_lat         <= 1'b0;
      quad_lat         <= '0;
    end else begin
      bus.sample_valid <= 1'b0;
      if (bus.new_note) begin
        for (int unsigned i = 0; i < 3; i++) phase[i] <= '0;
        acc <= '0;
        k   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              acc      <= '0;
              k        <= '0;
              note_lat <= bus.note_addr;
              play_lat <= bus.play;
            end
          end
          S_ADV: begin
            phase[k]     <= ph_new;
            // Odd quadrants read the quarter wave backwards
            bus.rom_addr <= q_new[0] ? ~idx_new : idx_new;
            quad_lat     <= q_new;
          end
          S_ACC: begin
            if (play_lat) acc <= acc + d_shift;
            k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
          end
          S_OUT: begin
            bus.sample_out   <= acc;
            bus.sample_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sample_reader.sv
module tb_note_sample_reader;

  logic clk;
  logic reset;
  logic [15:0] rom_q;

  int total = 0;
  int bad   = 0;
  int ph [3];
  int last_smp = 0;
  int dut_a0   = 0;

  note_sample_reader_if #(.ROM_AW(10), .SAMPLE_W(16)) bus ();

  note_sample_reader #(.PHASE_W(22), .ROM_AW(10), .SAMPLE_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: rom[i] = i*32, one clock of latency
  always @(posedge clk) rom_q <= {1'b0, bus.rom_addr, 5'b0};
  assign bus.rom_data = rom_q;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one request's worth of phase stepping and sine lookup
  function automatic void model_req(input logic [44:0] na, input bit pl,
                                    output int smp, output int a0);
    int acc, step, q, i, a, v;
    acc = 0;
    a0  = 0;
    for (int kk = 0; kk < 3; kk++) begin
      step = int'((na >> (15 * kk)) & 45'h7FFF);
      if (pl) ph[kk] = (ph[kk] + step) % (1 << 22);
      q = ph[kk] / (1 << 20);
      i = (ph[kk] / 1024) % 1024;
      a = (q % 2 == 1) ? 1023 - i : i;
      v = a * 32;
      if (q >= 2) v = -v;
      if (pl) acc += (kk == 0) ? (v >>> 1) : (v >>> 2);
      if (kk == 0) a0 = a;
    end
    smp = acc;
  endfunction

  task automatic request(input string tag, input int dup_at);
    int smp, a0, lat, nval;
    lat  = 0;
    nval = 0;
    model_req(bus.note_addr, bus.play, smp, a0);
    bus.generate_next = 1'b1;
    tick();
    for (int c = 1; c <= 13; c++) begin
      bus.generate_next = (c == dup_at);
      tick();
      if (c == 1) begin
        check({tag, ".busy"}, int'(bus.busy), 1);
        check({tag, ".rom_addr"}, int'(bus.rom_addr), a0);
        dut_a0 = int'(bus.rom_addr);
      end
      if (bus.sample_valid) begin
        nval++;
        if (lat == 0) lat = c;
      end
    end
    bus.generate_next = 1'b0;
    check({tag, ".latency"}, lat, 10);
    check({tag, ".nvalid"}, nval, 1);
    check({tag, ".sample"}, int'($signed(bus.sample_out)), smp);
    check({tag, ".idle"}, int'(bus.busy), 0);
    last_smp = smp;
  endtask

  task automatic quiet(input string tag, input int n);
    int nval;
    nval = 0;
    for (int c = 0; c < n; c++) begin
      tick();
      if (bus.sample_valid) nval++;
    end
    check({tag, ".nvalid"}, nval, 0);
  endtask

  task automatic pulse_new_note();
    bus.new_note = 1'b1;
    tick();
    bus.new_note = 1'b0;
    for (int kk = 0; kk < 3; kk++) ph[kk] = 0;
  endtask

  initial begin
    bit saw_neg;
    bus.note_addr     = '0;
    bus.new_note      = 1'b0;
    bus.play          = 1'b1;
    bus.generate_next = 1'b0;
    for (int kk = 0; kk < 3; kk++) ph[kk] = 0;

    // 1. reset with a request pending
    reset = 1'b1;
    bus.generate_next = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t1.valid_in_reset", int'(bus.sample_valid), 0);
    end
    check("t1.rom_addr", int'(bus.rom_addr), 0);
    check("t1.sample_out", int'(bus.sample_out), 0);
    check("t1.busy", int'(bus.busy), 0);
    reset = 1'b0;
    bus.generate_next = 1'b0;
    quiet("t1.after", 12);

    // 2. fundamental only
    bus.play = 1'b1;
    bus.note_addr = {15'd0, 15'd0, 15'd1024};
    for (int j = 0; j < 5; j++) begin
      request("t2", 0);
      check("t2.const", int'($signed(bus.sample_out)), 16 * (j + 1));
    end

    // 3. all three harmonics
    pulse_new_note();
    bus.note_addr = {15'd1024, 15'd1024, 15'd1024};
    for (int j = 0; j < 5; j++) begin
      request("t3", 0);
      check("t3.const", int'($signed(bus.sample_out)), 32 * (j + 1));
    end

    // 4. large step, across all quadrants
    pulse_new_note();
    bus.note_addr = {15'd0, 15'd0, 15'h7FFF};
    for (int j = 0; j < 33; j++) request("t4", 0);
    check("t4.addr33", dut_a0, 992);
    check("t4.sample33", int'($signed(bus.sample_out)), 15872);
    saw_neg = 1'b0;
    for (int j = 0; j < 70; j++) begin
      request("t4b", 0);
      if ($signed(bus.sample_out) < 0) saw_neg = 1'b1;
    end
    check("t4.negative_seen", int'(saw_neg), 1);

    // 5. request while busy is dropped; new_note aborts
    pulse_new_note();
    bus.note_addr = {15'd0, 15'd0, 15'd1024};
    request("t5.dup", 3);
    bus.generate_next = 1'b1;
    tick();
    bus.generate_next = 1'b0;
    tick(); tick(); tick();
    pulse_new_note();
    quiet("t5.abort", 13);
    check("t5.hold", int'($signed(bus.sample_out)), last_smp);
    request("t5.first", 0);
    check("t5.first_const", int'($signed(bus.sample_out)), 16);

    // 6. play=0 gives silence and freezes phases
    bus.note_addr = {15'd300, 15'd2000, 15'd5000};
    bus.play = 1'b0;
    request("t6.silent", 0);
    check("t6.zero", int'(bus.sample_out), 0);
    bus.play = 1'b1;
    request("t6.resume", 0);
    bus.new_note = 1'b1;
    bus.generate_next = 1'b1;
    tick();
    bus.new_note = 1'b0;
    bus.generate_next = 1'b0;
    for (int kk = 0; kk < 3; kk++) ph[kk] = 0;
    quiet("t6.collide", 13);
    check("t6.collide_busy", int'(bus.busy), 0);

    // Random notes, play and note changes
    for (int j = 0; j < 40; j++) begin
      bus.note_addr = {$urandom(), $urandom()};
      bus.play = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) pulse_new_note();
      request("rnd", ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
